// File: rtl/miner_pkg.sv
// Shared types and defaults for the miner's SOLVE-phase blocks.
package miner_pkg;

  localparam int NONCE_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLAIM = 2'd2,
    DONE  = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, pointer moves to winner+1 on each grant.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] ptr;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && en && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (valid) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Hands disjoint nonce chunks to the hash cores and funnels their candidates to the verifier.
module nonce_dispatcher
  import miner_pkg::*;
#(
  parameter  int NUM_CORES = 4,
  parameter  int NONCE_W   = NONCE_W_DEF,
  parameter  int CHUNK_LG2 = 20,
  localparam int IW        = $clog2(NUM_CORES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_CORES-1:0]           chunk_req,
  output logic [NUM_CORES-1:0]           chunk_gnt,
  output logic [NONCE_W-1:0]             chunk_base,
  input  logic [NUM_CORES-1:0]           found,
  input  logic [NUM_CORES*NONCE_W-1:0]   found_nonce,
  output logic [NUM_CORES-1:0]           found_ack,
  output logic                           sol_claim,
  output logic [NONCE_W-1:0]             claim_nonce,
  output logic [IW-1:0]                  claim_core,
  input  logic                           sol_verified,
  input  logic                           sol_rejected,
  output logic                           solved,
  output logic                           exhausted
);

  localparam logic [NONCE_W:0] CHUNK = {{NONCE_W{1'b0}}, 1'b1} << CHUNK_LG2;

  dispatch_state_t state, state_next;

  logic [NONCE_W:0]   next_base;
  logic [NONCE_W:0]   base_sum;
  logic               restart;
  logic               grant_en, claim_en;
  logic [NUM_CORES-1:0] g_gnt, c_gnt;
  logic [IW-1:0]      unused_grant_idx, c_idx;
  logic               g_valid, c_valid;

  // Enables depend only on registered state so the arbiters never feed back into them.
  assign claim_en = (state == RUN) && !abort;
  assign grant_en = claim_en && !exhausted;
  assign base_sum = next_base + CHUNK;

  rr_arbiter #(.N(NUM_CORES)) u_grant_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (grant_en),
    .req   (chunk_req),
    .gnt   (g_gnt),
    .idx   (unused_grant_idx),
    .valid (g_valid)
  );

  rr_arbiter #(.N(NUM_CORES)) u_claim_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (claim_en),
    .req   (found),
    .gnt   (c_gnt),
    .idx   (c_idx),
    .valid (c_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    restart    = 1'b0;
    case (state)
      IDLE:  if (start) begin restart = 1'b1; state_next = RUN; end
      RUN:   if (c_valid) state_next = CLAIM;
      CLAIM: begin
        if (sol_verified)      state_next = DONE;
        else if (sol_rejected) state_next = RUN;
      end
      DONE:  if (start) begin restart = 1'b1; state_next = RUN; end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      restart    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_base   <= '0;
      chunk_gnt   <= '0;
      chunk_base  <= '0;
      found_ack   <= '0;
      sol_claim   <= 1'b0;
      claim_nonce <= '0;
      claim_core  <= '0;
      solved      <= 1'b0;
      exhausted   <= 1'b0;
    end else begin
      chunk_gnt <= '0;
      found_ack <= '0;
      if (abort) begin
        next_base   <= '0;
        chunk_base  <= '0;
        sol_claim   <= 1'b0;
        claim_nonce <= '0;
        claim_core  <= '0;
        solved      <= 1'b0;
        exhausted   <= 1'b0;
      end else begin
        if (restart) begin
          next_base <= '0;
          exhausted <= 1'b0;
          solved    <= 1'b0;
        end
        // Carry out of the base adder marks the whole nonce space as handed out.
        if (g_valid) begin
          chunk_gnt  <= g_gnt;
          chunk_base <= next_base[NONCE_W-1:0];
          next_base  <= base_sum;
          exhausted  <= base_sum[NONCE_W];
        end
        if (c_valid) begin
          found_ack   <= c_gnt;
          claim_nonce <= found_nonce[int'(c_idx)*NONCE_W +: NONCE_W];
          claim_core  <= c_idx;
          sol_claim   <= 1'b1;
        end
        if (state == CLAIM && (sol_verified || sol_rejected)) begin
          sol_claim <= 1'b0;
          solved    <= sol_verified;
        end
      end
    end
  end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed + randomized bench for nonce_dispatcher with a round-robin/arithmetic reference model.
module tb_nonce_dispatcher;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LG = 20;
  localparam longint CHUNK = longint'(1) << LG;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (32-bit nonces, 1M-nonce chunks)
  logic           rst, start, abort, sol_verified, sol_rejected;
  logic [N-1:0]   chunk_req, chunk_gnt, found, found_ack;
  logic [W-1:0]   chunk_base, claim_nonce;
  logic [N*W-1:0] found_nonce;
  logic           sol_claim, solved, exhausted;
  logic [1:0]     claim_core;

  // Small instance to reach nonce-space exhaustion quickly
  logic           s_rst, s_start, s_abort, s_ver, s_rej;
  logic [N-1:0]   s_req, s_gnt, s_found, s_ack;
  logic [7:0]     s_base, s_claim_nonce;
  logic [N*8-1:0] s_found_nonce;
  logic           s_claim, s_solved, s_exh;
  logic [1:0]     s_claim_core;

  nonce_dispatcher #(.NUM_CORES(N), .NONCE_W(W), .CHUNK_LG2(LG)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .chunk_req(chunk_req), .chunk_gnt(chunk_gnt), .chunk_base(chunk_base),
    .found(found), .found_nonce(found_nonce), .found_ack(found_ack),
    .sol_claim(sol_claim), .claim_nonce(claim_nonce), .claim_core(claim_core),
    .sol_verified(sol_verified), .sol_rejected(sol_rejected),
    .solved(solved), .exhausted(exhausted)
  );

  nonce_dispatcher #(.NUM_CORES(N), .NONCE_W(8), .CHUNK_LG2(6)) dut2 (
    .clk(clk), .rst(s_rst), .start(s_start), .abort(s_abort),
    .chunk_req(s_req), .chunk_gnt(s_gnt), .chunk_base(s_base),
    .found(s_found), .found_nonce(s_found_nonce), .found_ack(s_ack),
    .sol_claim(s_claim), .claim_nonce(s_claim_nonce), .claim_core(s_claim_core),
    .sol_verified(s_ver), .sol_rejected(s_rej),
    .solved(s_solved), .exhausted(s_exh)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: round-robin pointers and the next chunk base as plain numbers
  int     gptr = 0;
  int     cptr = 0;
  longint base = 0;
  logic [W-1:0] slot [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, ".gnt"},   64'(chunk_gnt),   64'h0);
    check({tag, ".base"},  64'(chunk_base),  64'h0);
    check({tag, ".ack"},   64'(found_ack),   64'h0);
    check({tag, ".claim"}, 64'(sol_claim),   64'h0);
    check({tag, ".cnon"},  64'(claim_nonce), 64'h0);
    check({tag, ".ccore"}, 64'(claim_core),  64'h0);
    check({tag, ".solv"},  64'(solved),      64'h0);
    check({tag, ".exh"},   64'(exhausted),   64'h0);
  endtask

  // Expected grant for the request vector presented before the last edge
  task automatic expect_grant(input string tag, input logic [N-1:0] req);
    int w;
    w = rr_pick(req, gptr);
    if (w < 0) begin
      check({tag, ".nogrant"}, 64'(chunk_gnt), 64'h0);
    end else begin
      check({tag, ".gnt"},  64'(chunk_gnt),  64'(1 << w));
      check({tag, ".base"}, 64'(chunk_base), 64'(base));
      base = base + CHUNK;
      gptr = (w + 1) % N;
    end
  endtask

  // Expected claim capture for the found vector presented before the last edge
  task automatic expect_claim(input string tag, input logic [N-1:0] fnd);
    int w;
    w = rr_pick(fnd, cptr);
    check({tag, ".ack"},   64'(found_ack),   64'(1 << w));
    check({tag, ".claim"}, 64'(sol_claim),   64'h1);
    check({tag, ".ccore"}, 64'(claim_core),  64'(w));
    check({tag, ".cnon"},  64'(claim_nonce), 64'(slot[w]));
    cptr = (w + 1) % N;
  endtask

  task automatic load_nonces();
    for (int i = 0; i < N; i++) begin
      slot[i] = $urandom;
      found_nonce[i*W +: W] = slot[i];
    end
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] f;
    longint sbase;

    rst = 1'b1; start = 0; abort = 0; sol_verified = 0; sol_rejected = 0;
    chunk_req = '0; found = '0; found_nonce = '0;
    s_rst = 1'b1; s_start = 0; s_abort = 0; s_ver = 0; s_rej = 0;
    s_req = '0; s_found = '0; s_found_nonce = '0;
    repeat (2) step();
    rst = 1'b0; s_rst = 1'b0;
    step();
    check_zero("reset");

    // All four cores requesting: consecutive one-hot grants in core order
    start = 1'b1; step(); start = 1'b0;
    chunk_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1.gnt_lit",  64'(chunk_gnt),  64'(1 << k));
      check("t1.base_lit", 64'(chunk_base), 64'(k * 32'h0010_0000));
      expect_grant("t1", chunk_req);
    end

    // Random request patterns
    for (int k = 0; k < 40; k++) begin
      r = 4'($urandom_range(0, 15));
      chunk_req = r;
      step();
      expect_grant("rg", r);
    end
    chunk_req = '0;
    step();
    check("rg.idle_gnt", 64'(chunk_gnt), 64'h0);
    check("rg.exh", 64'(exhausted), 64'h0);

    // Two candidates: lower-priority-from-pointer core1 wins, then core2 after reject
    load_nonces();
    found = 4'b0110;
    step();
    check("t3.core_lit", 64'(claim_core), 64'h1);
    expect_claim("t3a", 4'b0110);
    chunk_req = 4'b1111;
    step();
    check("t3.claim_noack", 64'(found_ack), 64'h0);
    check("t3.claim_nognt", 64'(chunk_gnt), 64'h0);
    check("t3.claim_held",  64'(sol_claim), 64'h1);
    chunk_req = '0;
    found = 4'b0100;
    sol_rejected = 1'b1;
    step();
    sol_rejected = 1'b0;
    check("t3.rej_claim", 64'(sol_claim), 64'h0);
    check("t3.rej_ack",   64'(found_ack), 64'h0);
    step();
    check("t3.ack_lit", 64'(found_ack), 64'h4);
    expect_claim("t3b", 4'b0100);

    // Verified and rejected together: verified wins
    found = '0;
    sol_verified = 1'b1; sol_rejected = 1'b1;
    step();
    sol_verified = 1'b0; sol_rejected = 1'b0;
    check("t4.solved", 64'(solved),      64'h1);
    check("t4.claim",  64'(sol_claim),   64'h0);
    check("t4.cnon",   64'(claim_nonce), 64'(slot[2]));
    check("t4.ccore",  64'(claim_core),  64'h2);
    found = 4'b1000; chunk_req = 4'b1111;
    step();
    check("t4.done_ack",  64'(found_ack), 64'h0);
    check("t4.done_gnt",  64'(chunk_gnt), 64'h0);
    check("t4.done_hold", 64'(solved),    64'h1);

    // Restart from DONE, then abort a pending claim
    found = '0; chunk_req = '0;
    start = 1'b1; step(); start = 1'b0;
    check("t5.solved_clr", 64'(solved), 64'h0);
    base = 0;
    chunk_req = 4'b0001;
    step();
    expect_grant("t5", 4'b0001);
    chunk_req = '0;
    load_nonces();
    found = 4'b1000;
    step();
    expect_claim("t5", 4'b1000);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_zero("t5.abort");
    step();
    check("t5.idle_ack",   64'(found_ack), 64'h0);
    check("t5.idle_claim", 64'(sol_claim), 64'h0);
    found = '0;

    // Random claims with concurrent random requests
    start = 1'b1; step(); start = 1'b0;
    base = 0;
    for (int k = 0; k < 12; k++) begin
      load_nonces();
      f = 4'($urandom_range(1, 15));
      r = 4'($urandom_range(0, 15));
      found = f; chunk_req = r;
      step();
      expect_claim("rc", f);
      expect_grant("rc", r);
      found = '0;
      chunk_req = 4'($urandom_range(0, 15));
      sol_rejected = 1'b1;
      step();
      sol_rejected = 1'b0;
      check("rc.rej_gnt",   64'(chunk_gnt), 64'h0);
      check("rc.rej_claim", 64'(sol_claim), 64'h0);
      check("rc.rej_solv",  64'(solved),    64'h0);
    end
    chunk_req = '0;

    // Asynchronous reset between edges
    chunk_req = 4'b1111;
    step();
    expect_grant("t6.pre", 4'b1111);
    #2 rst = 1'b1;
    #1;
    check_zero("t6.rst");
    chunk_req = '0;
    #1 rst = 1'b0;
    gptr = 0; cptr = 0; base = 0;
    step();
    start = 1'b1; step(); start = 1'b0;
    chunk_req = 4'b1111;
    step();
    check("t6.gnt_lit", 64'(chunk_gnt), 64'h1);
    expect_grant("t6", 4'b1111);
    chunk_req = '0;

    // Small instance: 8-bit space, 64-nonce chunks, single requester
    s_start = 1'b1; step(); s_start = 1'b0;
    s_req = 4'b0100;
    sbase = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t2.gnt",  64'(s_gnt),  64'h4);
      check("t2.base", 64'(s_base), 64'(sbase));
      sbase = sbase + 64;
      check("t2.exh",  64'(s_exh),  64'(sbase >= 256));
    end
    repeat (3) begin
      step();
      check("t2.nogrant", 64'(s_gnt), 64'h0);
    end
    check("t2.exh_hold", 64'(s_exh), 64'h1);
    s_req = '0;
    s_abort = 1'b1; step(); s_abort = 1'b0;
    check("t2.abort_exh", 64'(s_exh), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
